// File: rtl/psum_drain_scheduler.sv
// psum_drain_scheduler: round-robin drain of per-column psum packets
// into a single-ported output SRAM with per-(column, filter) addressing.
module psum_drain_scheduler #(
    parameter int NUM_COL        = 7,
    parameter int NUM_FILTER_MAX = 4,
    parameter int PSUM_W         = 16,
    parameter int DEPTH          = 55,
    parameter int ADDR_W         = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_drain,
    input  logic [2:0]                num_filter,
    input  logic [5:0]                num_psum,
    input  logic [NUM_COL-1:0]        col_valid,
    input  logic [NUM_COL*2-1:0]      col_filter_idx,
    input  logic [NUM_COL*PSUM_W-1:0] col_psum,
    output logic [NUM_COL-1:0]        col_ack,
    output logic                      mem_wen,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [PSUM_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int CW = $clog2(NUM_COL);
    localparam int FW = 2;
    localparam int NW = 6;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     rr_q, rr_d;
    logic [2:0]        nf_q, nf_d;
    logic [NW-1:0]     np_q, np_d;
    logic [NW-1:0]     cnt_q [NUM_COL][NUM_FILTER_MAX];
    logic [NW-1:0]     cnt_d [NUM_COL][NUM_FILTER_MAX];
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PSUM_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              gnt_vld;
    logic [CW-1:0]     gnt_col;
    logic [FW-1:0]     gnt_f;
    logic [NW-1:0]     gnt_cnt;
    logic              can_issue;
    logic              pkt_ok;
    logic              issue;
    logic              all_full;
    int                idx;

    // first valid column strictly after the last granted one, with wrap
    always_comb begin
        gnt_vld = 1'b0;
        gnt_col = '0;
        idx     = 0;
        for (int i = 1; i <= NUM_COL; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_COL) idx = idx - NUM_COL;
            if (!gnt_vld && col_valid[CW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_col = CW'(idx);
            end
        end
    end

    assign gnt_f     = col_filter_idx[gnt_col*FW +: FW];
    assign gnt_cnt   = cnt_q[gnt_col][gnt_f];
    assign can_issue = !wen_q || mem_ready;
    assign pkt_ok    = ({1'b0, gnt_f} < nf_q) && (gnt_cnt < np_q);
    assign issue     = (state_q == DRAIN) && can_issue && gnt_vld && !rst;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        nf_d     = nf_q;
        np_d     = np_q;
        cnt_d    = cnt_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        col_ack  = '0;
        all_full = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start_drain) begin
                    state_d = DRAIN;
                    nf_d    = num_filter;
                    np_d    = num_psum;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    for (int c = 0; c < NUM_COL; c++)
                        for (int f = 0; f < NUM_FILTER_MAX; f++)
                            cnt_d[c][f] = '0;
                end
            end
            DRAIN: begin
                if (wen_q && mem_ready) wen_d = 1'b0;
                if (issue) begin
                    col_ack[gnt_col] = 1'b1;
                    rr_d = gnt_col;
                    // violating packets are still popped, just never written
                    if (pkt_ok) begin
                        cnt_d[gnt_col][gnt_f] = gnt_cnt + 1'b1;
                        wen_d   = 1'b1;
                        wdata_d = col_psum[gnt_col*PSUM_W +: PSUM_W];
                        addr_d  = ADDR_W'((int'(gnt_f) * NUM_COL + int'(gnt_col))
                                  * DEPTH + int'(gnt_cnt));
                    end else begin
                        err_d = 1'b1;
                    end
                end
                for (int c = 0; c < NUM_COL; c++)
                    for (int f = 0; f < NUM_FILTER_MAX; f++)
                        if (f < int'(nf_q) && cnt_d[c][f] != np_q)
                            all_full = 1'b0;
                if (all_full) state_d = FLUSH;
            end
            FLUSH: begin
                if (can_issue) begin
                    wen_d   = 1'b0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= CW'(NUM_COL - 1);
            nf_q    <= '0;
            np_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int c = 0; c < NUM_COL; c++)
                for (int f = 0; f < NUM_FILTER_MAX; f++)
                    cnt_q[c][f] <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            nf_q    <= nf_d;
            np_q    <= np_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wen   = wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_psum_drain_scheduler.sv
// tb_psum_drain_scheduler: job table, hand sequences and a per-cycle
// reference model of the round-robin drain scheduler.
module tb_psum_drain_scheduler;
    localparam int NC  = 7;
    localparam int NFM = 4;
    localparam int PW  = 16;
    localparam int DP  = 55;
    localparam int AW  = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_drain;
    logic [2:0]       num_filter;
    logic [5:0]       num_psum;
    logic [NC-1:0]    col_valid;
    logic [NC*2-1:0]  col_filter_idx;
    logic [NC*PW-1:0] col_psum;
    logic [NC-1:0]    col_ack;
    logic             mem_wen;
    logic [AW-1:0]    mem_addr;
    logic [PW-1:0]    mem_wdata;
    logic             mem_ready;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    psum_drain_scheduler #(
        .NUM_COL(NC), .NUM_FILTER_MAX(NFM), .PSUM_W(PW),
        .DEPTH(DP), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start_drain(start_drain),
        .num_filter(num_filter), .num_psum(num_psum),
        .col_valid(col_valid), .col_filter_idx(col_filter_idx),
        .col_psum(col_psum), .col_ack(col_ack),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
    );

    typedef struct { int f; int d; } pkt_t;
    typedef struct {
        int nf; int np; int rmode; int mmode; int bad;
        int ew; int ee; int ea;
    } vec_t;

    pkt_t colq [NC][$];
    vec_t tbl [6];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit   m_busy, m_flush, m_wen, m_done, m_err;
    int   m_nf, m_np, m_last, m_addr, m_wdata;
    int   m_cnt [NC][NFM];

    int   rmode, mmode, cyc, wr_cnt, wr_max, first_addr, drv_nf, drv_np;
    logic [NC-1:0] fix_mask;
    logic [NC-1:0] dut_acks [$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_flush = 0; m_wen = 0; m_done = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_last = NC - 1;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NFM; f++) m_cnt[c][f] = 0;
    endtask

    task automatic fill(input int nf, input int np, input int bad);
        pkt_t p;
        for (int c = 0; c < NC; c++) colq[c].delete();
        for (int c = 0; c < NC; c++) begin
            if (c == 0 && bad != 0) begin
                p.f = (bad == 1) ? 3 : 0;
                p.d = int'($urandom_range(0, 65535));
                colq[c].push_back(p);
            end
            for (int k = 0; k < np; k++)
                for (int f = 0; f < nf; f++) begin
                    p.f = f;
                    p.d = int'($urandom_range(0, 65535));
                    colq[c].push_back(p);
                end
        end
    endtask

    task automatic drive(input bit r, input bit st);
        logic [NC-1:0] msk;
        rst         = r;
        start_drain = st;
        num_filter  = 3'(drv_nf);
        num_psum    = 6'(drv_np);
        case (rmode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = !(cyc >= 3 && cyc < 7);
        endcase
        case (mmode)
            0:       msk = '1;
            1:       msk = NC'($urandom);
            default: msk = fix_mask;
        endcase
        for (int c = 0; c < NC; c++) begin
            if (colq[c].size() > 0 && msk[c]) begin
                col_valid[c]          = 1'b1;
                col_filter_idx[c*2+:2] = 2'(colq[c][0].f);
                col_psum[c*PW+:PW]    = PW'(colq[c][0].d);
            end else begin
                col_valid[c]          = 1'b0;
                col_filter_idx[c*2+:2] = 2'($urandom);
                col_psum[c*PW+:PW]    = PW'($urandom);
            end
        end
    endtask

    task automatic tick(input bit r, input bit st);
        int   g;
        int   c;
        bit   all;
        pkt_t p;
        @(negedge clk);
        drive(r, st);
        #1;
        if (!r && mem_wen && mem_ready) begin
            if (wr_cnt == 0) first_addr = int'(mem_addr);
            wr_cnt++;
            if (int'(mem_addr) > wr_max) wr_max = int'(mem_addr);
        end
        if (col_ack != '0) dut_acks.push_back(col_ack);
        g = -1;
        if (!r && m_busy && !m_flush && (!m_wen || mem_ready))
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (g < 0 && col_valid[c]) g = c;
            end
        check("col_ack", col_ack, (g < 0) ? 0 : (1 << g));
        m_done = 0;
        if (r) begin
            model_reset();
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_flush = 0; m_err = 0;
                m_nf = drv_nf; m_np = drv_np;
                for (int cc = 0; cc < NC; cc++)
                    for (int f = 0; f < NFM; f++) m_cnt[cc][f] = 0;
            end
        end else if (!m_flush) begin
            if (m_wen && mem_ready) m_wen = 0;
            if (g >= 0) begin
                p = colq[g].pop_front();
                m_last = g;
                if (p.f < m_nf && m_cnt[g][p.f] < m_np) begin
                    m_wen   = 1;
                    m_addr  = (p.f * NC + g) * DP + m_cnt[g][p.f];
                    m_wdata = p.d;
                    m_cnt[g][p.f]++;
                end else begin
                    m_err = 1;
                end
            end
            all = 1;
            for (int cc = 0; cc < NC; cc++)
                for (int f = 0; f < m_nf; f++)
                    if (m_cnt[cc][f] != m_np) all = 0;
            if (all) m_flush = 1;
        end else if (!m_wen || mem_ready) begin
            m_wen = 0; m_busy = 0; m_flush = 0; m_done = 1;
        end
        @(posedge clk);
        #1;
        check("mem_wen", mem_wen, m_wen);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("err", err, m_err);
        cyc++;
    endtask

    task automatic run_job(input int nf, input int np, input int budget);
        int n;
        drv_nf = nf; drv_np = np;
        wr_cnt = 0; wr_max = 0; first_addr = -1; cyc = 0;
        tick(0, 1);
        n = 0;
        while (m_busy && n < budget) begin
            if (rmode == 1) begin
                drv_nf = int'($urandom_range(1, 4));
                drv_np = int'($urandom_range(1, 55));
                tick(0, 1'($urandom_range(0, 1)));
            end else begin
                tick(0, 0);
            end
            n++;
        end
        if (m_busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: job still busy after %0d cycles", n);
            tick(1, 0);
        end
    endtask

    initial begin
        int exp_rr [6];
        int n;
        tbl[0] = '{1, 1,  0, 0, 0,    7, 0,  330};
        tbl[1] = '{2, 2,  2, 0, 0,   28, 0,  716};
        tbl[2] = '{2, 1,  0, 0, 1,   14, 1,  715};
        tbl[3] = '{2, 1,  0, 0, 2,   14, 1,  715};
        tbl[4] = '{4, 55, 0, 0, 0, 1540, 0, 1539};
        tbl[5] = '{3, 5,  1, 1, 0,  105, 0, 1104};

        rst = 1'b1; start_drain = 1'b0; num_filter = '0; num_psum = '0;
        col_valid = '0; col_filter_idx = '0; col_psum = '0; mem_ready = 1'b1;
        rmode = 0; mmode = 0; fix_mask = '1; drv_nf = 1; drv_np = 1; cyc = 0;
        wr_cnt = 0; wr_max = 0; first_addr = -1;
        for (int c = 0; c < NC; c++) colq[c].delete();
        model_reset();
        tick(1, 0);
        tick(1, 0);

        for (int i = 0; i < 6; i++) begin
            rmode = tbl[i].rmode;
            mmode = tbl[i].mmode;
            fill(tbl[i].nf, tbl[i].np, tbl[i].bad);
            run_job(tbl[i].nf, tbl[i].np, 4000);
            check("job_writes", wr_cnt, tbl[i].ew);
            check("job_err", err, tbl[i].ee);
            check("job_max_addr", wr_max, tbl[i].ea);
            rmode = 0; mmode = 0;
            tick(0, 0);
        end

        // round-robin between two permanently valid columns
        exp_rr = '{2, 5, 2, 5, 2, 5};
        mmode = 2; fix_mask = 7'b0100100;
        tick(1, 0);
        fill(1, 3, 0);
        drv_nf = 1; drv_np = 3; wr_cnt = 0; cyc = 0;
        tick(0, 1);
        dut_acks.delete();
        n = 0;
        while (dut_acks.size() < 6 && n < 50) begin
            tick(0, 0);
            n++;
        end
        check("rr_ack_count", dut_acks.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < dut_acks.size())
                check("rr_order", dut_acks[i], 1 << exp_rr[i]);
        repeat (3) tick(0, 0);
        check("rr_still_busy", busy, 1);
        fix_mask = '1;
        n = 0;
        while (m_busy && n < 200) begin
            tick(0, 0);
            n++;
        end
        check("rr_writes", wr_cnt, 21);
        mmode = 0;

        // reset in the middle of a drain, then a clean job
        fill(2, 2, 0);
        drv_nf = 2; drv_np = 2; cyc = 0;
        tick(0, 1);
        repeat (5) tick(0, 0);
        tick(1, 0);
        check("rst_busy", busy, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_done", done, 0);
        tick(0, 0);
        check("rst_no_done", done, 0);
        fill(1, 1, 0);
        run_job(1, 1, 100);
        check("rst_first_addr", first_addr, 0);
        check("rst_writes", wr_cnt, 7);
        check("rst_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
